// File: rtl/diffeq_pkg.sv
// Shared types and default constants for the iterative differential-equation solver.
package diffeq_pkg;

   localparam int unsigned DefWidth = 32;
   localparam int unsigned DefC5    = 5;
   localparam int unsigned DefC3    = 3;

   // Controller states: Idle -> Check -> (Mul -> Upd -> Check)* -> Done -> Idle
   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StMul,
      StUpd,
      StDone
   } state_e;

endpackage

// File: rtl/diffeq_mul_stage.sv
// Product register stage: captures u*dx, C5*x and C3*y in one cycle for the update step.
module diffeq_mul_stage
   import diffeq_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned C5    = DefC5,
   parameter int unsigned C3    = DefC3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] u,
   input  logic [WIDTH-1:0] dx,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] temp,
   output logic [WIDTH-1:0] p5,
   output logic [WIDTH-1:0] p3
);

   localparam logic [WIDTH-1:0] C5W = WIDTH'(C5);
   localparam logic [WIDTH-1:0] C3W = WIDTH'(C3);

   // Register the three products when the controller is in its multiply state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         temp <= '0;
         p5   <= '0;
         p3   <= '0;
      end else if (load) begin
         temp <= u * dx;
         p5   <= C5W * x;
         p3   <= C3W * y;
      end
   end

endmodule

// File: rtl/diffeq_solver_param.sv
// Multi-cycle differential-equation solver with start/busy/done handshake and iteration cap.
module diffeq_solver_param
   import diffeq_pkg::*;
#(
   parameter int unsigned WIDTH      = DefWidth,
   parameter int unsigned C5         = DefC5,
   parameter int unsigned C3         = DefC3,
   parameter int unsigned MAX_ITER   = 1024,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned SIGNED_CMP = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] dx_in,
   input  logic [WIDTH-1:0] x0_in,
   input  logic [WIDTH-1:0] y0_in,
   input  logic [WIDTH-1:0] u0_in,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] iter_count,
   output logic [WIDTH-1:0] xport,
   output logic [WIDTH-1:0] yport,
   output logic [WIDTH-1:0] uport
);

   state_e           state;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] dx;
   logic [WIDTH-1:0] temp;
   logic [WIDTH-1:0] p5;
   logic [WIDTH-1:0] p3;
   logic             x_lt_a;
   logic             cap_hit;
   logic             mul_load;

   assign x_lt_a   = (SIGNED_CMP != 0) ? ($signed(xport) < $signed(a)) : (xport < a);
   assign cap_hit  = (iter_count == CNT_W'(MAX_ITER));
   assign mul_load = (state == StMul);

   diffeq_mul_stage #(
      .WIDTH (WIDTH),
      .C5    (C5),
      .C3    (C3)
   ) u_mul (
      .clk   (clk),
      .reset (reset),
      .load  (mul_load),
      .u     (uport),
      .dx    (dx),
      .x     (xport),
      .y     (yport),
      .temp  (temp),
      .p5    (p5),
      .p3    (p3)
   );

   // Controller and state update; all outputs are registered here
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= StIdle;
         busy       <= 1'b0;
         done       <= 1'b0;
         timeout    <= 1'b0;
         iter_count <= '0;
         xport      <= '0;
         yport      <= '0;
         uport      <= '0;
         a          <= '0;
         dx         <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            StIdle: begin
               if (start) begin
                  a          <= a_in;
                  dx         <= dx_in;
                  xport      <= x0_in;
                  yport      <= y0_in;
                  uport      <= u0_in;
                  iter_count <= '0;
                  timeout    <= 1'b0;
                  busy       <= 1'b1;
                  state      <= StCheck;
               end
            end
            StCheck: begin
               // The cap wins over the loop bound when both hold in the same check
               if (cap_hit) begin
                  timeout <= 1'b1;
                  state   <= StDone;
               end else if (x_lt_a) begin
                  state <= StMul;
               end else begin
                  state <= StDone;
               end
            end
            StMul: begin
               state <= StUpd;
            end
            StUpd: begin
               xport      <= xport + dx;
               yport      <= yport + temp;
               uport      <= uport - temp * p5 - dx * p3;
               iter_count <= iter_count + CNT_W'(1);
               state      <= StCheck;
            end
            StDone: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_diffeq_solver_param.sv
// Self-checking bench: two solver instances (cap 4 / unsigned, cap 1024 / signed) checked
// every cycle against a behavioural model, plus hand-computed literal expectations.
module tb_diffeq_solver_param;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] a_in, dx_in, x0_in, y0_in, u0_in;

   logic [1:0]  busy, done, tmo;
   logic [15:0] ic [2];
   logic [31:0] xp [2];
   logic [31:0] yp [2];
   logic [31:0] up [2];

   diffeq_solver_param #(
      .WIDTH(32), .C5(5), .C3(3), .MAX_ITER(4), .CNT_W(16), .SIGNED_CMP(0)
   ) dut0 (
      .clk(clk), .reset(reset), .start(start), .a_in(a_in), .dx_in(dx_in),
      .x0_in(x0_in), .y0_in(y0_in), .u0_in(u0_in), .busy(busy[0]), .done(done[0]),
      .timeout(tmo[0]), .iter_count(ic[0]), .xport(xp[0]), .yport(yp[0]), .uport(up[0])
   );

   diffeq_solver_param #(
      .WIDTH(32), .C5(5), .C3(3), .MAX_ITER(1024), .CNT_W(16), .SIGNED_CMP(1)
   ) dut1 (
      .clk(clk), .reset(reset), .start(start), .a_in(a_in), .dx_in(dx_in),
      .x0_in(x0_in), .y0_in(y0_in), .u0_in(u0_in), .busy(busy[1]), .done(done[1]),
      .timeout(tmo[1]), .iter_count(ic[1]), .xport(xp[1]), .yport(yp[1]), .uport(up[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit cmp_en   = 1'b0;
   int mode     = 0;   // 0: expect reset values, 1: run launched at s_cyc
   int s_cyc    = 0;
   int lat [2];
   int done_at [2];
   logic [31:0] ex [2];
   logic [31:0] ey [2];
   logic [31:0] eu [2];
   int en [2];
   bit eto [2];
   int max_it [2] = '{4, 1024};
   bit sgn [2]    = '{1'b0, 1'b1};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Plain iteration of the recurrence, truncated to 32 bits
   function automatic void model(input logic [31:0] a, dx, x0, y0, u0, input int mx, input bit s,
                                 output logic [31:0] xo, yo, uo, output int n, output bit to);
      logic [31:0] x, y, u, t, nu;
      bit lt;
      x = x0; y = y0; u = u0; n = 0; to = 1'b0;
      while (1) begin
         if (n == mx) begin
            to = 1'b1;
            break;
         end
         lt = s ? ($signed(x) < $signed(a)) : (x < a);
         if (!lt) break;
         t  = u * dx;
         nu = u - t * (32'd5 * x) - dx * (32'd3 * y);
         x  = x + dx;
         y  = y + t;
         u  = nu;
         n++;
      end
      xo = x; yo = y; uo = u;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Compare process: every cycle, both instances against the model
   always @(posedge clk) begin
      #1;
      if (cmp_en) begin
         for (int k = 0; k < 2; k++) begin
            if (done[k]) done_at[k] = cyc;
            if (mode == 0) begin
               chk($sformatf("d%0d_rst_busy", k), 64'(busy[k]), 64'd0);
               chk($sformatf("d%0d_rst_done", k), 64'(done[k]), 64'd0);
               chk($sformatf("d%0d_rst_tmo", k), 64'(tmo[k]), 64'd0);
               chk($sformatf("d%0d_rst_iter", k), 64'(ic[k]), 64'd0);
               chk($sformatf("d%0d_rst_x", k), 64'(xp[k]), 64'd0);
               chk($sformatf("d%0d_rst_y", k), 64'(yp[k]), 64'd0);
               chk($sformatf("d%0d_rst_u", k), 64'(up[k]), 64'd0);
            end else if (cyc < s_cyc + lat[k]) begin
               chk($sformatf("d%0d_busy_run", k), 64'(busy[k]), 64'd1);
               chk($sformatf("d%0d_done_run", k), 64'(done[k]), 64'd0);
            end else begin
               chk($sformatf("d%0d_busy_end", k), 64'(busy[k]), 64'd0);
               chk($sformatf("d%0d_done", k), 64'(done[k]),
                   64'(cyc == s_cyc + lat[k]));
               chk($sformatf("d%0d_x", k), 64'(xp[k]), 64'(ex[k]));
               chk($sformatf("d%0d_y", k), 64'(yp[k]), 64'(ey[k]));
               chk($sformatf("d%0d_u", k), 64'(up[k]), 64'(eu[k]));
               chk($sformatf("d%0d_iter", k), 64'(ic[k]), 64'(en[k]));
               chk($sformatf("d%0d_tmo", k), 64'(tmo[k]), 64'(eto[k]));
            end
         end
      end
   end

   task automatic set_expect(input logic [31:0] a, dx, x0, y0, u0);
      for (int k = 0; k < 2; k++) begin
         model(a, dx, x0, y0, u0, max_it[k], sgn[k], ex[k], ey[k], eu[k], en[k], eto[k]);
         lat[k]     = 3 * en[k] + 2;
         done_at[k] = -1;
      end
   endtask

   task automatic launch(input logic [31:0] a, dx, x0, y0, u0, input bit hold);
      @(negedge clk);
      a_in = a; dx_in = dx; x0_in = x0; y0_in = y0; u0_in = u0;
      start = 1'b1;
      set_expect(a, dx, x0, y0, u0);
      s_cyc = cyc + 1;
      mode  = 1;
      if (!hold) begin
         @(negedge clk);
         start = 1'b0;
         // Operand changes while busy must not disturb the run
         a_in = $urandom; dx_in = $urandom; x0_in = $urandom; y0_in = $urandom;
         u0_in = $urandom;
      end
   endtask

   task automatic wait_end();
      int m;
      m = (lat[0] > lat[1]) ? lat[0] : lat[1];
      while (cyc <= s_cyc + m + 1) @(negedge clk);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0;
      a_in = '0; dx_in = '0; x0_in = '0; y0_in = '0; u0_in = '0;
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Two iterations: x=2, y=2, u=-7
      launch(32'd2, 32'd1, 32'd0, 32'd0, 32'd1, 1'b0);
      wait_end();
      chk("t1_lat", 64'(done_at[0] - s_cyc), 64'd8);
      chk("t1_x", 64'(xp[0]), 64'd2);
      chk("t1_y", 64'(yp[0]), 64'd2);
      chk("t1_u", 64'(up[0]), 64'hFFFF_FFF9);
      chk("t1_iter", 64'(ic[0]), 64'd2);
      chk("t1_tmo", 64'(tmo[0]), 64'd0);

      // Zero iterations
      launch(32'd0, 32'd7, 32'd0, 32'd11, 32'd13, 1'b0);
      wait_end();
      chk("t2_lat", 64'(done_at[1] - s_cyc), 64'd2);
      chk("t2_y", 64'(yp[1]), 64'd11);
      chk("t2_u", 64'(up[1]), 64'd13);
      chk("t2_iter", 64'(ic[1]), 64'd0);

      // Cap on dut0 (MAX_ITER=4), dut1 runs to 100
      launch(32'd100, 32'd1, 32'd0, 32'd0, 32'd0, 1'b0);
      wait_end();
      chk("t3_lat", 64'(done_at[0] - s_cyc), 64'd14);
      chk("t3_x", 64'(xp[0]), 64'd4);
      chk("t3_iter", 64'(ic[0]), 64'd4);
      chk("t3_tmo", 64'(tmo[0]), 64'd1);
      chk("t3_iter1", 64'(ic[1]), 64'd100);
      chk("t3_tmo1", 64'(tmo[1]), 64'd0);

      // Signed vs unsigned compare with negative x0
      launch(32'd5, 32'd3, 32'hFFFF_FFFE, 32'd0, 32'd0, 1'b0);
      wait_end();
      chk("t4_iter_s", 64'(ic[1]), 64'd3);
      chk("t4_x_s", 64'(xp[1]), 64'd7);
      chk("t4_iter_u", 64'(ic[0]), 64'd0);
      chk("t4_x_u", 64'(xp[0]), 64'hFFFF_FFFE);

      // Sign-boundary bound and a general vector
      launch(32'h8000_0000, 32'd1, 32'h7FFF_FFFE, 32'd1, 32'd3, 1'b0);
      wait_end();
      chk("t5_iter_u", 64'(ic[0]), 64'd2);
      chk("t5_iter_s", 64'(ic[1]), 64'd0);
      launch(32'd10, 32'd3, 32'd1, 32'd7, 32'd2, 1'b0);
      wait_end();

      // Reset in the multiply state of the second iteration
      launch(32'd2, 32'd1, 32'd0, 32'd0, 32'd1, 1'b0);
      while (cyc < s_cyc + 4) @(negedge clk);
      reset = 1'b0;
      mode  = 0;
      #1;
      chk("rst_busy", 64'(busy[0]), 64'd0);
      chk("rst_x", 64'(xp[0]), 64'd0);
      chk("rst_iter", 64'(ic[0]), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      launch(32'd2, 32'd1, 32'd0, 32'd0, 32'd1, 1'b0);
      wait_end();
      chk("t6_u", 64'(up[0]), 64'hFFFF_FFF9);

      // Start held through the run and the done cycle: one run, then a second one
      launch(32'd2, 32'd1, 32'd0, 32'd0, 32'd1, 1'b1);
      while (cyc < s_cyc + lat[0]) @(negedge clk);
      chk("hold_done", 64'(done[0]), 64'd1);
      s_cyc = s_cyc + lat[0] + 1;
      @(negedge clk);
      start = 1'b0;
      wait_end();
      chk("hold_lat2", 64'(done_at[0] - s_cyc), 64'd8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/diffeq_solver_param.md
Name: diffeq_solver_param

Overview:
Parametrised, multi-cycle successor to the single-step differential-equation solver. It iterates x'=x+dx, y'=y+u*dx, u'=u-(u*dx)*(C5*x)-dx*(C3*y) from loaded initial values until x is no longer less than a, or until an iteration cap is hit. Control is a start/busy/done handshake. It sits as a compute kernel behind a host or controller that supplies operands and collects results.

Parameters:
WIDTH, 32, datapath width of a, dx, x, y, u and all intermediate products.
C5, 5, coefficient applied to x in the u update.
C3, 3, coefficient applied to y in the u update.
MAX_ITER, 1024, iteration cap; must be >=1.
CNT_W, 16, width of the iteration counter; 2^CNT_W must be > MAX_ITER.
SIGNED_CMP, 0, 0 = unsigned x<a compare, 1 = two's-complement compare.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
start  in  1  request a run; sampled only in IDLE
a_in  in  WIDTH  loop bound a, captured on start
dx_in  in  WIDTH  step dx, captured on start
x0_in  in  WIDTH  initial x
y0_in  in  WIDTH  initial y
u0_in  in  WIDTH  initial u
busy  out  1  high from the cycle after start is accepted until DONE is left
done  out  1  one-cycle pulse when results are valid
timeout  out  1  valid with done; 1 = run ended by the MAX_ITER cap
iter_count  out  CNT_W  number of completed iterations
xport  out  WIDTH  current/final x
yport  out  WIDTH  current/final y
uport  out  WIDTH  current/final u

Behaviour:
- Reset (reset=0, async): state=IDLE. busy, done, timeout, iter_count, xport, yport, uport, a, dx, temp and product registers all 0. Reset mid-run aborts with no done pulse.
- States: IDLE, CHECK, MUL, UPD, DONE.
- IDLE, start=1: latch a_in, dx_in, x0/y0/u0 into xport/yport/uport; iter_count=0; timeout=0; go to CHECK. start in any other state is ignored.
- CHECK: if iter_count==MAX_ITER then timeout=1 and go to DONE. Else if x<a (compare per SIGNED_CMP) go to MUL. Else go to DONE.
- MUL: register three products: temp=u*dx, p5=C5*x, p3=C3*y. Go to UPD.
- UPD: x+=dx; y+=temp; u=u-temp*p5-dx*p3; iter_count+=1; go to CHECK.
- DONE: done=1 for exactly one cycle, busy=0 next cycle, return to IDLE.
- Arithmetic: every product and sum is truncated to the low WIDTH bits (modulo 2^WIDTH). There is no saturation. Overflow of x wraps and is not detected.
- Latency: done asserts 3*N+2 cycles after the start edge, where N is iter_count. Per-iteration throughput is 3 cycles.
- Outputs hold their final values after done until the next accepted start.
- A start in the DONE cycle is ignored; a new run may start from the following cycle.
- MAX_ITER reached in the same CHECK where x>=a: timeout=1 (cap has priority).
- a_in/dx_in changes during busy have no effect.

Decomposition:
- Shared package diffeq_pkg holds the state enum/localparams (IDLE..DONE) and the default WIDTH/C5/C3 constants.
- One natural sub-module, diffeq_mul_stage: the MUL-state product registers (temp, p5, p3), parametrised by WIDTH/C5/C3, with load enable. The FSM and update logic stay in the top.

Test Plan:
- WIDTH=32, a=2, dx=1, x0=0, y0=0, u0=1, start -> done 8 cycles after the start edge, iter_count=2, x=2, y=2, u=0xFFFFFFF9, timeout=0.
- a=0, x0=0 -> done 2 cycles after start, iter_count=0, outputs equal x0/y0/u0, timeout=0.
- MAX_ITER=4, a=100, dx=1, x0=y0=u0=0 -> done at cycle 14, iter_count=4, x=4, y=0, u=0, timeout=1.
- SIGNED_CMP=1, a=5, x0=0xFFFFFFFE (-2), dx=3, y0=u0=0 -> 3 iterations, x=7. SIGNED_CMP=0 with the same operands -> 0 iterations.
- Pulse reset low during the MUL state of iteration 2 -> all outputs 0 immediately, no done pulse. After release, a fresh start completes normally.
- Hold start high for the whole run plus the DONE cycle -> exactly one run and one done pulse, a second run starts the cycle after DONE, and busy stays high throughout the second run.
